// File: rtl/tpm_buf_arbiter.sv
// rtl/tpm_buf_arbiter.sv - WB/DP round-robin arbiter for the TPM buffer RAM (option macro: TPM_BUF_EXEC_LOCK_EN)
module tpm_buf_arbiter #(
  parameter int BUF_ADDR_WIDTH = 11,
  parameter int RAM_RD_LATENCY = 1
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [BUF_ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [31:0]               wb_dat_i,
  input  logic [3:0]                wb_sel_i,
  input  logic                      wb_we_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_cyc_i,
  output logic [31:0]               wb_dat_o,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  input  logic [BUF_ADDR_WIDTH-1:0] dp_addr_i,
  input  logic [7:0]                dp_wdata_i,
  input  logic                      dp_we_i,
  input  logic                      dp_req_i,
  output logic [7:0]                dp_rdata_o,
  output logic                      dp_ack_o,
  output logic                      dp_err_o,
  input  logic                      exec_i,
  output logic [BUF_ADDR_WIDTH-3:0] ram_a_o,
  output logic [31:0]               ram_wd_o,
  output logic [3:0]                ram_wen_o,
  input  logic [31:0]               ram_rd_i
);

  typedef enum logic [1:0] {IDLE, ACC, WAIT, RESP} state_t;

  localparam logic GNT_WB = 1'b0;
  localparam logic GNT_DP = 1'b1;

  state_t     state;
  logic       last_grant;
  logic       owner_dp;
  logic       abort;
  logic [1:0] lane;

  logic wb_req;
  logic dp_req;
  logic grant_any;
  logic grant_dp;
  logic owner_drop;
  logic illegal;

  // Address byte-offset bits of the WB port and exec_i (when unlocked) carry no function.
  logic unused_bits;
  assign unused_bits = &{1'b0, exec_i, wb_adr_i[1:0]};

  // Request qualification, round-robin pick and ownership check for the IDLE grant.
  always_comb begin
    wb_req     = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    dp_req     = dp_req_i & ~dp_ack_o & ~dp_err_o;
    grant_any  = wb_req | dp_req;
    grant_dp   = dp_req & (~wb_req | (last_grant == GNT_WB));
    owner_drop = owner_dp ? ~dp_req_i : ~wb_cyc_i;
`ifdef TPM_BUF_EXEC_LOCK_EN
    illegal    = grant_dp ? exec_i : ~exec_i;
`else
    illegal    = 1'b0;
`endif
  end

  // Transaction FSM; every output is a register so no input reaches an output combinationally.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      last_grant <= GNT_WB;
      owner_dp   <= 1'b0;
      abort      <= 1'b0;
      lane       <= 2'd0;
      wb_dat_o   <= 32'd0;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      dp_rdata_o <= 8'd0;
      dp_ack_o   <= 1'b0;
      dp_err_o   <= 1'b0;
      ram_a_o    <= '0;
      ram_wd_o   <= 32'd0;
      ram_wen_o  <= 4'd0;
    end else begin
      wb_ack_o <= 1'b0;
      dp_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      dp_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            last_grant <= grant_dp;
            owner_dp   <= grant_dp;
            abort      <= 1'b0;
            lane       <= dp_addr_i[1:0];
            if (illegal) begin
              // Refused owner: error pulse next cycle, RAM untouched, stay in IDLE.
              wb_err_o <= ~grant_dp;
              dp_err_o <= grant_dp;
            end else if (grant_dp) begin
              ram_a_o   <= dp_addr_i[BUF_ADDR_WIDTH-1:2];
              ram_wd_o  <= {4{dp_wdata_i}};
              ram_wen_o <= dp_we_i ? (4'b0001 << dp_addr_i[1:0]) : 4'd0;
              state     <= ACC;
            end else begin
              ram_a_o   <= wb_adr_i[BUF_ADDR_WIDTH-1:2];
              ram_wd_o  <= wb_dat_i;
              ram_wen_o <= wb_we_i ? wb_sel_i : 4'd0;
              state     <= ACC;
            end
          end
        end
        ACC: begin
          // RAM samples at the end of this cycle; the write strobe lasts exactly one cycle.
          ram_wen_o <= 4'd0;
          abort     <= abort | owner_drop;
          state     <= (RAM_RD_LATENCY > 1) ? WAIT : RESP;
        end
        WAIT: begin
          abort <= abort | owner_drop;
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          if (!(abort | owner_drop)) begin
            if (owner_dp) begin
              dp_ack_o   <= 1'b1;
              dp_rdata_o <= ram_rd_i[{lane, 3'b000} +: 8];
            end else begin
              wb_ack_o <= 1'b1;
              wb_dat_o <= ram_rd_i;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpm_buf_arbiter.sv
// tb/tb_tpm_buf_arbiter.sv - self-checking bench for tpm_buf_arbiter with a RAM model and reference memory
module tb_tpm_buf_arbiter;

  logic        clk;
  logic        rstn;
  logic [10:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_cyc;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [10:0] dp_addr;
  logic [7:0]  dp_wdata;
  logic        dp_we;
  logic        dp_req;
  logic [7:0]  dp_rdata_o;
  logic        dp_ack_o;
  logic        dp_err_o;
  logic        exec_r;
  logic [8:0]  ram_a;
  logic [31:0] ram_wd;
  logic [3:0]  ram_wen;
  logic [31:0] ram_rd;

  int errors = 0;
  int checks = 0;

  tpm_buf_arbiter dut (
    .clk_i(clk), .rstn_i(rstn),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel), .wb_we_i(wb_we),
    .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .dp_addr_i(dp_addr), .dp_wdata_i(dp_wdata), .dp_we_i(dp_we),
    .dp_req_i(dp_req), .dp_rdata_o(dp_rdata_o), .dp_ack_o(dp_ack_o), .dp_err_o(dp_err_o),
    .exec_i(exec_r), .ram_a_o(ram_a), .ram_wd_o(ram_wd), .ram_wen_o(ram_wen), .ram_rd_i(ram_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous 512x32 RAM, one cycle read latency, byte write enables.
  logic        clr_ram;
  logic [31:0] ram [0:511];
  always @(posedge clk) begin
    if (clr_ram) begin
      for (int i = 0; i < 512; i++) ram[i] <= 32'd0;
      ram_rd <= 32'd0;
    end else begin
      ram_rd <= ram[ram_a];
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) ram[ram_a][8*b +: 8] <= ram_wd[8*b +: 8];
    end
  end

  // Every cycle with a nonzero write strobe is logged; one entry per write means a one-cycle pulse.
  typedef struct packed {logic [3:0] wen; logic [8:0] a; logic [31:0] wd;} wev_t;
  wev_t wq[$];
  always @(negedge clk) if (ram_wen != 4'd0) wq.push_back({ram_wen, ram_a, ram_wd});

  // Reference memory: what the buffer must contain after the accepted writes.
  logic [31:0] ref_mem [0:511];

  task automatic ref_wb_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a[10:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic ref_dp_write(input logic [10:0] a, input logic [7:0] d);
    ref_mem[a[10:2]][8*a[1:0] +: 8] = d;
  endtask

  task automatic wb_access(input logic we, input logic [10:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output int lat);
    int n = 0;
    lat = -1; rd = 32'hx;
    wb_adr = a; wb_dat = d; wb_sel = s; wb_we = we; exec_r = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    while (n < 20 && lat < 0) begin
      @(posedge clk); #1; n++;
      if (wb_ack_o) begin lat = n; rd = wb_dat_o; end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic dp_access(input logic we, input logic [10:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output int lat);
    int n = 0;
    lat = -1; rd = 8'hx;
    dp_addr = a; dp_wdata = d; dp_we = we; exec_r = 1'b0; dp_req = 1'b1;
    while (n < 20 && lat < 0) begin
      @(posedge clk); #1; n++;
      if (dp_ack_o) begin lat = n; rd = dp_rdata_o; end
    end
    dp_req = 1'b0; dp_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; clr_ram = 1'b1;
    wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 0; wb_stb = 0; wb_cyc = 0;
    dp_addr = '0; dp_wdata = '0; dp_we = 0; dp_req = 0; exec_r = 0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'd0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if ({wb_ack_o, wb_err_o, dp_ack_o, dp_err_o} !== 4'd0) begin errors++;
      $display("FAIL reset_acks: got %b required 0000", {wb_ack_o, wb_err_o, dp_ack_o, dp_err_o}); end
    checks++; if ({wb_dat_o, dp_rdata_o} !== 40'd0) begin errors++;
      $display("FAIL reset_rdata: got %h required 0", {wb_dat_o, dp_rdata_o}); end
    checks++; if ({ram_a, ram_wd, ram_wen} !== 45'd0) begin errors++;
      $display("FAIL reset_ram_ctl: got %h required 0", {ram_a, ram_wd, ram_wen}); end
    clr_ram = 1'b0; rstn = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if ({wb_ack_o, dp_ack_o, ram_wen} !== 6'd0) begin errors++;
      $display("FAIL reset_idle: got %b required 0", {wb_ack_o, dp_ack_o, ram_wen}); end
  endtask

  task automatic test_wb_write_read();
    logic [31:0] rd; int lat; wev_t e;
    wq.delete();
    wb_access(1'b1, 11'h010, 32'hA1B2C3D4, 4'b0110, rd, lat);
    ref_wb_write(11'h010, 32'hA1B2C3D4, 4'b0110);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wb_write_latency: got %0d required 3", lat); end
    e = (wq.size() > 0) ? wq[0] : '0;
    checks++; if (wq.size() !== 1 || e !== {4'b0110, 9'd4, 32'hA1B2C3D4}) begin errors++;
      $display("FAIL wb_write_strobe: got n=%0d %h required n=1 %h", wq.size(), e, {4'b0110, 9'd4, 32'hA1B2C3D4}); end
    wb_access(1'b0, 11'h010, 32'd0, 4'hF, rd, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wb_read_latency: got %0d required 3", lat); end
    checks++; if (rd !== 32'h00B2C300) begin errors++; $display("FAIL wb_read_data: got %h required 00b2c300", rd); end
  endtask

  task automatic test_dp_bytes();
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] rb; logic [31:0] rd; int lat; wev_t e; wev_t x;
    wq.delete();
    for (int i = 0; i < 4; i++) begin
      dp_access(1'b1, 11'(32'h20 + i), bytes[i], rb, lat);
      ref_dp_write(11'(32'h20 + i), bytes[i]);
      checks++; if (lat !== 3) begin errors++; $display("FAIL dp_write_latency[%0d]: got %0d required 3", i, lat); end
    end
    checks++; if (wq.size() !== 4) begin errors++; $display("FAIL dp_strobe_count: got %0d required 4", wq.size()); end
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      e = wq[i];
      x = {4'(4'b0001 << i), 9'd8, {4{bytes[i]}}};
      checks++; if (e !== x) begin errors++; $display("FAIL dp_strobe[%0d]: got %h required %h", i, e, x); end
    end
    wb_access(1'b0, 11'h020, 32'd0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h44332211) begin errors++; $display("FAIL dp_word_readback: got %h required 44332211", rd); end
    for (int i = 0; i < 4; i++) begin
      dp_access(1'b0, 11'(32'h20 + i), 8'd0, rb, lat);
      checks++; if (rb !== bytes[i] || lat !== 3) begin errors++;
        $display("FAIL dp_read[%0d]: got %h lat %0d required %h lat 3", i, rb, lat, bytes[i]); end
    end
  endtask

  task automatic test_cyc_drop();
    int acks; logic [31:0] rd; logic [7:0] rb; int lat; wev_t e;
    // WB read abandoned in cycle 1
    acks = 0;
    wb_adr = 11'h010; wb_we = 1'b0; wb_sel = 4'hF; exec_r = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1; wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (wb_ack_o) acks++; end
    checks++; if (acks !== 0) begin errors++; $display("FAIL wb_drop_read_ack: got %0d acks required 0", acks); end
    // WB write abandoned in cycle 1 still lands
    acks = 0; wq.delete();
    wb_adr = 11'h030; wb_dat = 32'hCAFEF00D; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (wb_ack_o) acks++; end
    ref_wb_write(11'h030, 32'hCAFEF00D, 4'hF);
    e = (wq.size() > 0) ? wq[0] : '0;
    checks++; if (acks !== 0 || wq.size() !== 1 || e !== {4'hF, 9'd12, 32'hCAFEF00D}) begin errors++;
      $display("FAIL wb_drop_write: acks=%0d n=%0d %h required acks=0 n=1 %h", acks, wq.size(), e, {4'hF, 9'd12, 32'hCAFEF00D}); end
    wb_access(1'b0, 11'h030, 32'd0, 4'hF, rd, lat);
    checks++; if (rd !== ref_mem[12] || lat !== 3) begin errors++;
      $display("FAIL wb_after_drop: got %h lat %0d required %h lat 3", rd, lat, ref_mem[12]); end
    // DP read abandoned in cycle 1
    acks = 0;
    dp_addr = 11'h021; dp_we = 1'b0; exec_r = 1'b0; dp_req = 1'b1;
    @(posedge clk); #1; dp_req = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (dp_ack_o) acks++; end
    checks++; if (acks !== 0) begin errors++; $display("FAIL dp_drop_ack: got %0d acks required 0", acks); end
    dp_access(1'b0, 11'h021, 8'd0, rb, lat);
    checks++; if (rb !== ref_mem[8][15:8] || lat !== 3) begin errors++;
      $display("FAIL dp_after_drop: got %h lat %0d required %h lat 3", rb, lat, ref_mem[8][15:8]); end
  endtask

  task automatic test_arbitration();
    int ack_cyc [$]; logic ack_dp [$]; logic [39:0] ack_dat [$];
    pulse_reset();
    wb_adr = 11'h020; wb_we = 1'b0; wb_sel = 4'hF; dp_addr = 11'h021; dp_we = 1'b0;
    wb_cyc = 1'b1; wb_stb = 1'b1; dp_req = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin ack_cyc.push_back(n); ack_dp.push_back(1'b0); ack_dat.push_back({8'd0, wb_dat_o}); end
      if (dp_ack_o) begin ack_cyc.push_back(n); ack_dp.push_back(1'b1); ack_dat.push_back({32'd0, dp_rdata_o}); end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; dp_req = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (ack_cyc.size() !== 8) begin errors++; $display("FAIL arb_ack_count: got %0d required 8", ack_cyc.size()); end
    for (int k = 0; k < 8 && k < ack_cyc.size(); k++) begin
      logic exp_dp = (k % 2 == 0);
      logic [39:0] exp_d = exp_dp ? {32'd0, ref_mem[8][15:8]} : {8'd0, ref_mem[8]};
      checks++;
      if (ack_dp[k] !== exp_dp || ack_cyc[k] !== 3 * (k + 1) || ack_dat[k] !== exp_d) begin errors++;
        $display("FAIL arb_grant[%0d]: got dp=%0b cyc=%0d d=%h required dp=%0b cyc=%0d d=%h",
                 k, ack_dp[k], ack_cyc[k], ack_dat[k], exp_dp, 3 * (k + 1), exp_d); end
    end
  endtask

  task automatic test_reset_mid();
    int first_cyc = -1; logic first_dp = 1'b0; logic [7:0] rb_first = 8'd0; logic [31:0] rd; int lat;
    dp_addr = 11'h1C4; dp_wdata = 8'h5A; dp_we = 1'b1; exec_r = 1'b0; dp_req = 1'b1;
    @(posedge clk); #1;
    checks++; if (ram_wen !== 4'b0001 || ram_a !== 9'h071) begin errors++;
      $display("FAIL midrst_acc: got wen=%b a=%h required wen=0001 a=071", ram_wen, ram_a); end
    rstn = 1'b0; #1;
    checks++; if ({wb_dat_o, wb_ack_o, wb_err_o, dp_rdata_o, dp_ack_o, dp_err_o, ram_a, ram_wd, ram_wen} !== '0) begin errors++;
      $display("FAIL midrst_async: got %h required 0", {wb_dat_o, wb_ack_o, wb_err_o, dp_rdata_o, dp_ack_o, dp_err_o, ram_a, ram_wd, ram_wen}); end
    dp_req = 1'b0; dp_we = 1'b0;
    @(posedge clk); #1; rstn = 1'b1;
    @(posedge clk); #1;
    wb_adr = 11'h020; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
    dp_addr = 11'h022; dp_req = 1'b1;
    for (int n = 1; n <= 10 && first_cyc < 0; n++) begin
      @(posedge clk); #1;
      if (wb_ack_o || dp_ack_o) begin first_cyc = n; first_dp = dp_ack_o; rb_first = dp_rdata_o; end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; dp_req = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (first_dp !== 1'b1 || first_cyc !== 3 || rb_first !== ref_mem[8][23:16]) begin errors++;
      $display("FAIL midrst_tie: got dp=%0b cyc=%0d d=%h required dp=1 cyc=3 d=%h", first_dp, first_cyc, rb_first, ref_mem[8][23:16]); end
    // the interrupted write has no guarantee; put the word back to a known value
    wb_access(1'b1, 11'h1C4, ref_mem[9'h071], 4'hF, rd, lat);
    wq.delete();
  endtask

  task automatic test_random();
    logic [31:0] rd; logic [7:0] rb; int lat; wev_t e; wev_t x; int exp_n;
    for (int k = 0; k < 60; k++) begin
      logic        use_dp = 1'($urandom_range(0, 1));
      logic        we     = 1'($urandom_range(0, 1));
      logic [10:0] a      = 11'($urandom_range(0, 63));
      logic [31:0] d      = $urandom;
      logic [3:0]  s      = 4'($urandom_range(0, 15));
      wq.delete();
      if (use_dp) begin
        dp_access(we, a, d[7:0], rb, lat);
        exp_n = we ? 1 : 0;
        x = {4'(4'b0001 << a[1:0]), a[10:2], {4{d[7:0]}}};
        if (we) ref_dp_write(a, d[7:0]);
        else begin
          checks++; if (rb !== ref_mem[a[10:2]][8*a[1:0] +: 8]) begin errors++;
            $display("FAIL rnd_dp_read[%0d]: got %h required %h", k, rb, ref_mem[a[10:2]][8*a[1:0] +: 8]); end
        end
      end else begin
        wb_access(we, a, d, s, rd, lat);
        exp_n = (we && s != 4'd0) ? 1 : 0;
        x = {s, a[10:2], d};
        if (we) ref_wb_write(a, d, s);
        else begin
          checks++; if (rd !== ref_mem[a[10:2]]) begin errors++;
            $display("FAIL rnd_wb_read[%0d]: got %h required %h", k, rd, ref_mem[a[10:2]]); end
        end
      end
      checks++; if (lat !== 3) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d required 3", k, lat); end
      e = (wq.size() > 0) ? wq[0] : '0;
      checks++; if (wq.size() !== exp_n || (exp_n == 1 && e !== x)) begin errors++;
        $display("FAIL rnd_strobe[%0d]: got n=%0d %h required n=%0d %h", k, wq.size(), e, exp_n, x); end
    end
    for (int w = 0; w < 16; w++) begin
      wb_access(1'b0, 11'(w * 4), 32'd0, 4'hF, rd, lat);
      checks++; if (rd !== ref_mem[w]) begin errors++; $display("FAIL rnd_sweep[%0d]: got %h required %h", w, rd, ref_mem[w]); end
    end
  endtask

`ifdef TPM_BUF_EXEC_LOCK_EN
  task automatic test_exec_lock();
    int err_cyc = -1; int err_cnt = 0; int ack_cnt = 0; logic [8:0] a_before; logic [7:0] rb; int lat;
    wq.delete(); exec_r = 1'b0; a_before = ram_a;
    wb_adr = 11'h050; wb_dat = 32'hDEADBEEF; wb_sel = 4'hF; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      if (wb_err_o) begin err_cnt++; if (err_cyc < 0) err_cyc = n; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; end
      if (wb_ack_o) ack_cnt++;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    checks++; if (err_cyc !== 1 || err_cnt !== 1 || ack_cnt !== 0) begin errors++;
      $display("FAIL lock_wb_err: got cyc=%0d n=%0d acks=%0d required cyc=1 n=1 acks=0", err_cyc, err_cnt, ack_cnt); end
    checks++; if (wq.size() !== 0 || ram_a !== a_before) begin errors++;
      $display("FAIL lock_no_access: got n=%0d a=%h required n=0 a=%h", wq.size(), ram_a, a_before); end
    dp_access(1'b0, 11'h023, 8'd0, rb, lat);
    checks++; if (rb !== ref_mem[8][31:24] || lat !== 3) begin errors++;
      $display("FAIL lock_dp_read: got %h lat %0d required %h lat 3", rb, lat, ref_mem[8][31:24]); end
  endtask
`endif

  initial begin
    test_reset();
    test_wb_write_read();
    test_dp_bytes();
    test_cyc_drop();
`ifndef TPM_BUF_EXEC_LOCK_EN
    test_arbitration();
`endif
    test_reset_mid();
    test_random();
`ifdef TPM_BUF_EXEC_LOCK_EN
    test_exec_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
